// File: rtl/dpram_pkg.sv
// Shared types and constants for the dual-port RAM with clear-on-reset.
package dpram_pkg;

    // Controller state: CLEAR zeroes the array after reset, RUN serves both ports.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Read-during-write selection when one port reads what the other writes.
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/dpram_core.sv
// Storage array with two write ports and two registered read ports.
// Reads always return the pre-edge word; the parent decides on forwarding.
module dpram_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              re0,
    input  logic [ADDR_W-1:0] ra0,
    input  logic              re1,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd0_d, rd0_q;
    logic [DATA_W-1:0] rd1_d, rd1_q;

    // Array writes; port 0 is applied last so it wins an address clash.
    always_ff @(posedge clk) begin
        if (we1) mem[wa1] <= wd1;
        if (we0) mem[wa0] <= wd0;
    end

    // Read registers load only on a read and otherwise hold their word.
    always_comb begin
        rd0_d = rd0_q;
        rd1_d = rd1_q;
        if (re0) rd0_d = mem[ra0];
        if (re1) rd1_d = mem[ra1];
    end

    // Read data registers, cleared by reset (the array itself is not).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            rd0_q <= rd0_d;
            rd1_q <= rd1_d;
        end
    end

    assign rd0 = rd0_q;
    assign rd1 = rd1_q;

endmodule

// File: rtl/dpram_param.sv
// Dual-port RAM top: clears the array after reset, then serves two
// read/write ports with write arbitration, clash reporting and a
// selectable read-during-write policy.
module dpram_param
    import dpram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] add0,
    input  logic [ADDR_W-1:0] add1,
    input  logic [DATA_W-1:0] data0_in,
    input  logic [DATA_W-1:0] data1_in,
    output logic [DATA_W-1:0] data0_out,
    output logic [DATA_W-1:0] data1_out,
    output logic              valid0,
    output logic              valid1,
    output logic              collision,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_d, state_q;
    logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
    logic              ready_d, ready_q;
    logic              valid0_d, valid0_q;
    logic              valid1_d, valid1_q;
    logic              collision_d, collision_q;
    // Forwarding: when set, the port shows the word the other port wrote.
    logic              fwd0_d, fwd0_q;
    logic              fwd1_d, fwd1_q;
    logic [DATA_W-1:0] fwd0_data_d, fwd0_data_q;
    logic [DATA_W-1:0] fwd1_data_d, fwd1_data_q;

    logic              run, rd0_req, rd1_req, wr0_req, wr1_req, clash;
    logic              fwd0_hit, fwd1_hit;
    logic              core_we0, core_we1;
    logic [ADDR_W-1:0] core_wa0;
    logic [DATA_W-1:0] core_wd0;
    logic [DATA_W-1:0] core_rd0, core_rd1;

    // Request decode, clash detect and core write-port steering.
    always_comb begin
        run      = (state_q == RUN);
        rd0_req  = run && en && !wr0;
        rd1_req  = run && en && !wr1;
        wr0_req  = run && en && wr0;
        wr1_req  = run && en && wr1;
        clash    = wr0_req && wr1_req && (add0 == add1);
        // Port 0 doubles as the clear engine while not running.
        core_we0 = run ? wr0_req  : 1'b1;
        core_wa0 = run ? add0     : clr_cnt_q;
        core_wd0 = run ? data0_in : '0;
        // Port 1 loses a same-address write clash.
        core_we1 = wr1_req && !clash;
        fwd0_hit = 1'b0;
        fwd1_hit = 1'b0;
        if (RDW_MODE == RDW_WRITE_FIRST) begin
            fwd0_hit = rd0_req && core_we1 && (add0 == add1);
            fwd1_hit = rd1_req && core_we0 && (add0 == add1);
        end
    end

    // Next-state logic: clear sequencing, status flags and forwarding.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == LAST_ADDR) state_d = RUN;
        end
        ready_d     = (state_d == RUN);
        valid0_d    = rd0_req;
        valid1_d    = rd1_req;
        collision_d = clash;
        fwd0_d      = rd0_req ? fwd0_hit : fwd0_q;
        fwd1_d      = rd1_req ? fwd1_hit : fwd1_q;
        fwd0_data_d = fwd0_hit ? data1_in : fwd0_data_q;
        fwd1_data_d = fwd1_hit ? data0_in : fwd1_data_q;
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            ready_q     <= 1'b0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
            collision_q <= 1'b0;
            fwd0_q      <= 1'b0;
            fwd1_q      <= 1'b0;
            fwd0_data_q <= '0;
            fwd1_data_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ready_q     <= ready_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
            collision_q <= collision_d;
            fwd0_q      <= fwd0_d;
            fwd1_q      <= fwd1_d;
            fwd0_data_q <= fwd0_data_d;
            fwd1_data_q <= fwd1_data_d;
        end
    end

    dpram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we0   (core_we0),
        .wa0   (core_wa0),
        .wd0   (core_wd0),
        .we1   (core_we1),
        .wa1   (add1),
        .wd1   (data1_in),
        .re0   (rd0_req),
        .ra0   (add0),
        .re1   (rd1_req),
        .ra1   (add1),
        .rd0   (core_rd0),
        .rd1   (core_rd1)
    );

    assign data0_out = fwd0_q ? fwd0_data_q : core_rd0;
    assign data1_out = fwd1_q ? fwd1_data_q : core_rd1;
    assign valid0    = valid0_q;
    assign valid1    = valid1_q;
    assign collision = collision_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_dpram_param.sv
// Bench for dpram_param: one read-first and one write-first instance driven
// in lockstep, checked against a word-array model and a directed table.
module tb_dpram_param;
    import dpram_pkg::*;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n, en, wr0, wr1;
    logic [AW-1:0] add0, add1;
    logic [DW-1:0] d0in, d1in;

    logic [DW-1:0] rf_d0, rf_d1, wf_d0, wf_d1;
    logic rf_v0, rf_v1, rf_col, rf_rdy;
    logic wf_v0, wf_v1, wf_col, wf_rdy;

    always #5 clk = ~clk;

    dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(RDW_READ_FIRST)) u_rf (
        .clk(clk), .rst_n(rst_n), .en(en), .wr0(wr0), .wr1(wr1),
        .add0(add0), .add1(add1), .data0_in(d0in), .data1_in(d1in),
        .data0_out(rf_d0), .data1_out(rf_d1), .valid0(rf_v0), .valid1(rf_v1),
        .collision(rf_col), .ready(rf_rdy)
    );

    dpram_param #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(RDW_WRITE_FIRST)) u_wf (
        .clk(clk), .rst_n(rst_n), .en(en), .wr0(wr0), .wr1(wr1),
        .add0(add0), .add1(add1), .data0_in(d0in), .data1_in(d1in),
        .data0_out(wf_d0), .data1_out(wf_d1), .valid0(wf_v0), .valid1(wf_v1),
        .collision(wf_col), .ready(wf_rdy)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: word array plus expected outputs ([0]=read-first, [1]=write-first).
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] e_d0 [2];
    logic [DW-1:0] e_d1 [2];
    logic e_v0, e_v1, e_col, e_rdy;

    typedef struct {
        logic          en;
        logic          wr0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          wr1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          v0;
        logic          v1;
        logic          col;
        logic [DW-1:0] rf0;
        logic [DW-1:0] rf1;
        logic [DW-1:0] wf0;
        logic [DW-1:0] wf1;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".rf_d0"},  rf_d0, e_d0[0]);
        chk({tag, ".rf_d1"},  rf_d1, e_d1[0]);
        chk({tag, ".wf_d0"},  wf_d0, e_d0[1]);
        chk({tag, ".wf_d1"},  wf_d1, e_d1[1]);
        chk({tag, ".rf_v0"},  DW'(rf_v0),  DW'(e_v0));
        chk({tag, ".rf_v1"},  DW'(rf_v1),  DW'(e_v1));
        chk({tag, ".wf_v0"},  DW'(wf_v0),  DW'(e_v0));
        chk({tag, ".wf_v1"},  DW'(wf_v1),  DW'(e_v1));
        chk({tag, ".rf_col"}, DW'(rf_col), DW'(e_col));
        chk({tag, ".wf_col"}, DW'(wf_col), DW'(e_col));
        chk({tag, ".rf_rdy"}, DW'(rf_rdy), DW'(e_rdy));
        chk({tag, ".wf_rdy"}, DW'(wf_rdy), DW'(e_rdy));
    endtask

    // One RUN-mode clock of the behavioural model, using the applied inputs.
    task automatic model_step();
        logic [DW-1:0] old0, old1;
        if (en) begin
            old0 = m_mem[add0];
            old1 = m_mem[add1];
            if (wr1) m_mem[add1] = d1in;
            if (wr0) m_mem[add0] = d0in;
            if (!wr0) begin e_d0[0] = old0; e_d0[1] = m_mem[add0]; end
            if (!wr1) begin e_d1[0] = old1; e_d1[1] = m_mem[add1]; end
            e_v0  = !wr0;
            e_v1  = !wr1;
            e_col = wr0 && wr1 && (add0 == add1);
        end else begin
            e_v0 = 1'b0; e_v1 = 1'b0; e_col = 1'b0;
        end
    endtask

    task automatic drive(input logic en_i, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] dd0,
                         input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] dd1);
        en = en_i; wr0 = w0; add0 = a0; d0in = dd0; wr1 = w1; add1 = a1; d1in = dd1;
    endtask

    task automatic cyc(input logic en_i, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] dd0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] dd1, input string tag);
        drive(en_i, w0, a0, dd0, w1, a1, dd1);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk_all(tag);
    endtask

    task automatic junk();
        drive(1'b1, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
    endtask

    // Reset, then walk the clear sequence with junk requests applied.
    // abort_at > 0 stops after that many clear cycles without finishing.
    task automatic do_reset(input int abort_at);
        rst_n = 1'b0;
        junk();
        repeat (2) begin @(posedge clk); @(negedge clk); end
        e_d0[0] = '0; e_d0[1] = '0; e_d1[0] = '0; e_d1[1] = '0;
        e_v0 = 1'b0; e_v1 = 1'b0; e_col = 1'b0; e_rdy = 1'b0;
        chk_all("reset");
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            junk();
            @(posedge clk);
            @(negedge clk);
            e_rdy = (i == DEPTH);
            chk_all($sformatf("clear%0d", i));
            if (i == abort_at) return;
        end
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    vec_t vt [13];
    logic [DW-1:0] b [8];

    initial begin
        vt[0]  = '{1'b1, 1'b1, 6'd9, 8'h11, 1'b1, 6'd10, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[1]  = '{1'b1, 1'b1, 6'd9, 8'h22, 1'b0, 6'd9,  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 8'h00, 8'h22};
        vt[2]  = '{1'b1, 1'b0, 6'd9, 8'h00, 1'b0, 6'd9,  8'h00, 1'b1, 1'b1, 1'b0, 8'h22, 8'h22, 8'h22, 8'h22};
        vt[3]  = '{1'b1, 1'b1, 6'd5, 8'hAA, 1'b1, 6'd5,  8'h55, 1'b0, 1'b0, 1'b1, 8'h22, 8'h22, 8'h22, 8'h22};
        vt[4]  = '{1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 6'd10, 8'h00, 1'b1, 1'b1, 1'b0, 8'hAA, 8'h33, 8'hAA, 8'h33};
        vt[5]  = '{1'b1, 1'b0, 6'd3, 8'h00, 1'b0, 6'd3,  8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[6]  = '{1'b0, 1'b1, 6'd3, 8'hFF, 1'b0, 6'd3,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[7]  = '{1'b1, 1'b0, 6'd3, 8'h00, 1'b1, 6'd5,  8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[8]  = '{1'b0, 1'b0, 6'd5, 8'h00, 1'b0, 6'd5,  8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[9]  = '{1'b1, 1'b1, 6'd6, 8'h44, 1'b0, 6'd5,  8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h77, 8'h00, 8'h77};
        vt[10] = '{1'b1, 1'b1, 6'd6, 8'h01, 1'b1, 6'd6,  8'h02, 1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 8'h00, 8'h77};
        vt[11] = '{1'b1, 1'b0, 6'd6, 8'h00, 1'b0, 6'd6,  8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01};
        vt[12] = '{1'b1, 1'b0, 6'd5, 8'h00, 1'b1, 6'd5,  8'h99, 1'b1, 1'b0, 1'b0, 8'h77, 8'h01, 8'h99, 8'h01};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        do_reset(-1);

        // Whole array reads back zero after the clear sequence.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b0, AW'(i), 8'h00, 1'b0, AW'(DEPTH - 1 - i), 8'h00, "zero_rd");

        // Directed table: clash, read-during-write in both modes, en=0, holds.
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].en, vt[i].wr0, vt[i].a0, vt[i].d0, vt[i].wr1, vt[i].a1, vt[i].d1);
            @(posedge clk);
            model_step();
            @(negedge clk);
            chk($sformatf("tbl%0d.rf_d0", i), rf_d0, vt[i].rf0);
            chk($sformatf("tbl%0d.rf_d1", i), rf_d1, vt[i].rf1);
            chk($sformatf("tbl%0d.wf_d0", i), wf_d0, vt[i].wf0);
            chk($sformatf("tbl%0d.wf_d1", i), wf_d1, vt[i].wf1);
            chk($sformatf("tbl%0d.v0", i),  DW'(rf_v0 & wf_v0 | (rf_v0 ^ wf_v0) & ~vt[i].v0), DW'(vt[i].v0));
            chk($sformatf("tbl%0d.v1", i),  DW'(rf_v1 & wf_v1 | (rf_v1 ^ wf_v1) & ~vt[i].v1), DW'(vt[i].v1));
            chk($sformatf("tbl%0d.col", i), DW'(rf_col & wf_col | (rf_col ^ wf_col) & ~vt[i].col), DW'(vt[i].col));
        end

        // Port 0 fills 0..7 with random bytes, port 1 reads them back.
        for (int i = 0; i < 8; i++) begin
            b[i] = DW'($urandom);
            cyc(1'b1, 1'b1, AW'(i), b[i], 1'b0, 6'd63, 8'h00, "fill");
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 6'd40, 8'h00, 1'b0, AW'(i), 8'h00, "readback");
            chk($sformatf("rb%0d.rf_d1", i), rf_d1, b[i]);
            chk($sformatf("rb%0d.wf_d1", i), wf_d1, b[i]);
            chk($sformatf("rb%0d.v1", i), DW'(rf_v1 & wf_v1), DW'(1'b1));
        end

        // Random traffic over a narrow address window to provoke clashes.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 9) != 0), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom),
                1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom), "rand");

        // Reset pulsed partway through clear restarts it from address 0.
        do_reset(30);
        do_reset(-1);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b0, AW'(i), 8'h00, 1'b0, AW'(i), 8'h00, "zero_rd2");
        for (int i = 0; i < 200; i++)
            cyc(1'($urandom_range(0, 7) != 0), 1'($urandom), AW'($urandom), DW'($urandom),
                1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), "rand2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dpram_param.md
DPRAM_PARAM -- requirements
Module: dpram_param

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits per word.
REQ-002 Parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RDW_MODE, default 0, read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 en  in  1  global enable for both ports.
REQ-007 wr0 / wr1  in  1  per-port op select: 1 = write, 0 = read.
REQ-008 add0 / add1  in  ADDR_W  per-port word address.
REQ-009 data0_in / data1_in  in  DATA_W  per-port write data.
REQ-010 data0_out / data1_out  out  DATA_W  per-port registered read data.
REQ-011 valid0 / valid1  out  1  read data valid on that port this cycle.
REQ-012 collision  out  1  one-cycle pulse on a write-write address clash.
REQ-013 ready  out  1  initialisation complete; ports accept operations.

Function
REQ-014 Two states: CLEAR and RUN; reset enters CLEAR.
REQ-015 CLEAR: write zero to address 0..DEPTH-1, one word per cycle, via an ADDR_W-bit counter; after address DEPTH-1 is written, go to RUN next cycle; ready = 1 only in RUN.
REQ-016 CLEAR: all port requests ignored; valid0/valid1/collision held 0.
REQ-017 RUN, en=1, wrP=1: dataP_in written to addP at the clock edge.
REQ-018 RUN, en=1, wrP=0: mem[addP] on dataP_out one cycle later, with validP = 1 for exactly that cycle.
REQ-019 No read on port P in a cycle: validP = 0 next cycle; dataP_out holds its last value.
REQ-020 en=0: no writes, no reads; valids 0 next cycle; outputs hold.
REQ-021 Both ports write the same address in one cycle: port 0 data stored, port 1 discarded; collision = 1 in the following cycle only.
REQ-022 Writes to different addresses in one cycle: both stored; collision stays 0.
REQ-023 One port reads, the other writes the same address in one cycle: RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns the newly written word.
REQ-024 Both ports read the same address: both return identical data; no collision.
REQ-025 Addresses are ADDR_W bits wide, so no out-of-range access exists; the clear counter wraps to 0 on exit from CLEAR.

Reset
REQ-026 rst_n sampled low at a rising edge: state = CLEAR, clear counter = 0, ready = 0, data0_out = data1_out = 0, valid0 = valid1 = 0, collision = 0.
REQ-027 rst_n asserted mid-CLEAR or mid-RUN: same as REQ-026; the clear sequence restarts from address 0.
REQ-028 Memory contents are not reset directly; they are zeroed only by the CLEAR sequence.

Structure
REQ-029 Shared package dpram_pkg holds the state enum (CLEAR, RUN) and the RDW_MODE constants RDW_READ_FIRST = 0 and RDW_WRITE_FIRST = 1.
REQ-030 Sub-module dpram_core holds the storage array with two write ports and two registered read ports.
REQ-031 dpram_param holds the state machine, clear counter, collision detect, write arbitration and RDW selection.

Verification
REQ-032 Reset with DATA_W=8, ADDR_W=6 -> ready rises exactly 64 cycles after the reset-release edge; reading addresses 0..63 returns 0x00.
REQ-033 Port 0 writes 8 random bytes to addresses 0..7; port 1 then reads 0..7 -> same bytes, one-cycle latency, valid1 = 1 on each read-data cycle.
REQ-034 Both ports write address 5 (port 0 0xAA, port 1 0x55) -> collision pulses one cycle; a later read of address 5 returns 0xAA.
REQ-035 Address 9 holds 0x11; port 0 writes 0x22 while port 1 reads address 9 -> RDW_MODE=0 returns 0x11, RDW_MODE=1 returns 0x22.
REQ-036 rst_n pulsed low at clear count 30 -> ready stays 0; clear restarts at 0; ready rises 64 cycles after release.
REQ-037 en=0 with wr0=1, add0=3, data0_in=0xFF -> valids stay 0; a later read of address 3 returns its previous value.
